instruction_fetch_unit: RTL and testbench

- Reader side of the fetch-address path: owns the fetch PC, issues one-at-a-time read requests to instruction memory and buffers the returned words for the decode stage.
- Sits between instruction memory and decode.
- Accepts branch/jump redirects from execute, flushing buffered and in-flight fetches.

---
 rtl/instruction_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one read at a time to
// instruction memory and queues returned words (with their PCs) for decode.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [1:0]  state_dbg_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e           state_q;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      req_addr_q;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic        push;
    logic        pop;
    logic        has_room;
    logic [31:0] redirect_target;
    logic [31:0] next_pc;

    // A redirect always wins: the word arriving with it is dropped.
    assign push            = (state_q == WAIT) && imem_ack && !redirect_valid;
    assign pop             = instr_valid && instr_ready;
    assign count_d         = count_q + CNT_W'(push) - CNT_W'(pop);
    assign has_room        = count_d < DEPTH_C;
    assign redirect_target = {redirect_addr[31:2], 2'b00};
    assign next_pc         = fetch_pc_q + 32'd4;

    assign imem_req    = (state_q != IDLE);
    assign imem_addr   = req_addr_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = data_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign state_dbg_o = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_ADDR;
            req_addr_q <= RESET_ADDR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            if (redirect_valid) begin
                fetch_pc_q <= redirect_target;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                count_q <= count_d;
                if (push) begin
                    pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
                    data_mem_q[wr_ptr_q] <= imem_rdata;
                    wr_ptr_q             <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end

            // req_addr_q only moves when a new request starts, so FLUSH
            // keeps presenting the address of the abandoned request.
            case (state_q)
                IDLE: begin
                    if (!redirect_valid && has_room) begin
                        state_q    <= WAIT;
                        req_addr_q <= fetch_pc_q;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        state_q <= imem_ack ? IDLE : FLUSH;
                    end else if (imem_ack) begin
                        fetch_pc_q <= next_pc;
                        req_addr_q <= next_pc;
                        if (!has_room) begin
                            state_q <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (imem_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic,
// all checked against a queue-based reference model of the fetch path.
module tb_instruction_fetch_unit;

    localparam int          DEPTH      = 2;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [1:0]  state_dbg;

    instruction_fetch_unit #(
        .RESET_ADDR(RESET_ADDR),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .state_dbg_o   (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: buffered words, one outstanding request that may be
    // marked as abandoned, and the PC the next new request will use.
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_q[$];
    bit          m_req;
    bit          m_discard;
    logic [31:0] m_addr;
    logic [31:0] m_next_pc;

    task automatic model_reset();
        exp_pc_q.delete();
        exp_q.delete();
        m_req     = 1'b0;
        m_discard = 1'b0;
        m_addr    = RESET_ADDR;
        m_next_pc = RESET_ADDR;
    endtask

    task automatic model_step();
        bit acked;
        acked = m_req && imem_ack;
        if (redirect_valid) begin
            exp_pc_q.delete();
            exp_q.delete();
            m_next_pc = redirect_addr & 32'hFFFF_FFFC;
            if (m_req && !imem_ack) begin
                m_discard = 1'b1;
            end else begin
                m_req     = 1'b0;
                m_discard = 1'b0;
            end
            return;
        end
        if (exp_q.size() != 0 && instr_ready) begin
            void'(exp_pc_q.pop_front());
            void'(exp_q.pop_front());
        end
        if (acked) begin
            m_req = 1'b0;
            if (m_discard) begin
                m_discard = 1'b0;
                return;
            end
            exp_pc_q.push_back(m_addr);
            exp_q.push_back(imem_rdata);
            m_next_pc = m_addr + 32'd4;
            if (exp_q.size() < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_next_pc;
            end
            return;
        end
        if (!m_req && exp_q.size() < DEPTH) begin
            m_req  = 1'b1;
            m_addr = m_next_pc;
        end
    endtask

    task automatic check_outputs();
        check("imem_req", imem_req, m_req);
        if (m_req) check("imem_addr", imem_addr, m_addr);
        check("instr_valid", instr_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("instr_pc", instr_pc, exp_pc_q[0]);
            check("instr_data", instr_data, exp_q[0]);
        end
    endtask

    // One clock: drive at the falling edge, step the model at the rising
    // edge, compare at the next falling edge.
    task automatic cycle(input bit redir, input logic [31:0] raddr, input bit ack,
                         input bit ready, input bit rinv);
        redirect_valid = redir;
        redirect_addr  = raddr;
        imem_ack       = ack;
        instr_ready    = ready;
        imem_rdata     = rinv ? ~imem_addr : $urandom;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        instr_ready    = 1'b0;
        reset          = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, RESET_ADDR);
        check("rst_valid", instr_valid, 0);
        check("rst_data", instr_data, 0);
        check("rst_pc", instr_pc, 0);
        reset = 1'b0;
    endtask

    logic [31:0] rtarget;

    initial begin
        // Zero-wait memory sustains one instruction per cycle.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
            check("p1_addr", imem_addr, 32'(4 * (k - 1)));
            if (k >= 2) begin
                check("p1_pc", instr_pc, 32'(4 * (k - 2)));
                check("p1_data", instr_data, ~32'(4 * (k - 2)));
            end else begin
                check("p1_valid0", instr_valid, 0);
            end
        end

        // Back-pressure: exactly DEPTH fetches, then fetching resumes.
        do_reset();
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("p2_req_idle", imem_req, 0);
        check("p2_pc_hold", instr_pc, 0);
        check("p2_valid", instr_valid, 1);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check("p2_resume_addr", imem_addr, 32'h8);
        check("p2_pc4", instr_pc, 32'h4);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check("p2_pc8", instr_pc, 32'h8);

        // Redirect while a slow request is outstanding.
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        check("p3_flush_addr", imem_addr, 32'h4);
        check("p3_flush_valid", instr_valid, 0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("p3_drop_req", imem_req, 0);
        check("p3_drop_valid", instr_valid, 0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("p3_target", imem_addr, 32'h100);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("p3_target_pc", instr_pc, 32'h100);

        // Redirect coinciding with an ack.
        do_reset();
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("p4_addr8", imem_addr, 32'h8);
        cycle(1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
        check("p4_empty", instr_valid, 0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("p4_target", imem_addr, 32'h200);

        // Unaligned target and PC wrap-around.
        cycle(1'b1, 32'h103, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("p5_align", imem_addr, 32'h100);
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("p5_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("p5_wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("p5_wrap_next", imem_addr, 32'h0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("p5_wrap_pc0", instr_pc, 32'h0);

        // Asynchronous reset between clock edges.
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("p6_pre_req", imem_req, 1);
        check("p6_pre_valid", instr_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("p6_async_req", imem_req, 0);
        check("p6_async_valid", instr_valid, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("p6_restart", imem_addr, RESET_ADDR);
        check("p6_no_stale", instr_valid, 0);

        // Random traffic with varying ack / ready / redirect rates.
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            int ack_pct;
            int rdy_pct;
            int red_pct;
            ack_pct = $urandom_range(20, 100);
            rdy_pct = $urandom_range(10, 100);
            red_pct = $urandom_range(0, 15);
            for (int n = 0; n < 500; n++) begin
                if ($urandom_range(0, 3) == 0) rtarget = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                else rtarget = $urandom;
                cycle(32'($urandom_range(0, 99)) < red_pct, rtarget,
                      32'($urandom_range(0, 99)) < ack_pct,
                      32'($urandom_range(0, 99)) < rdy_pct, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
